// File: rtl/alu_exec_unit_if.sv
// Issue port from the execution buffer into the ALU execution unit.
// The buffer drives the master side; alu_exec_unit consumes the slave side.
`ifndef NUM_D_REG
`define NUM_D_REG 8
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif
`ifndef ROB_LENGTH
`define ROB_LENGTH 8
`endif

interface alu_exec_unit_if #(
   parameter int RW  = $clog2(`NUM_D_REG),
   parameter int SW  = $clog2(`NUM_S_REG),
   parameter int QW  = $clog2(`ROB_LENGTH),
   parameter int IW  = 6,
   parameter int OPW = 4
);
   logic           valid;
   logic [QW-1:0]  rob_addr;
   logic [OPW-1:0] alu_op;
   logic [IW-1:0]  immdt;
   logic [RW-1:0]  ra_addr;
   logic           use_rt;
   logic [RW-1:0]  rt_addr;
   logic           write_dst;
   logic [RW-1:0]  rw_addr;
   logic [SW-1:0]  rs_addr;

   modport master (
      output valid, rob_addr, alu_op, immdt, ra_addr, use_rt, rt_addr, write_dst, rw_addr, rs_addr
   );
   modport slave (
      input valid, rob_addr, alu_op, immdt, ra_addr, use_rt, rt_addr, write_dst, rw_addr, rs_addr
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Two-stage ALU execution unit: S1 reads/latches operands, S2 executes and writes back.
// Optional ALU_BYPASS_EN forwards the live S2 result into S1 operands on an address match.
`ifndef NUM_D_REG
`define NUM_D_REG 8
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif
`ifndef ROB_LENGTH
`define ROB_LENGTH 8
`endif

module alu_exec_unit #(
   parameter  int DATA_W = 8,
   localparam int RW     = $clog2(`NUM_D_REG),
   localparam int SW     = $clog2(`NUM_S_REG),
   localparam int QW     = $clog2(`ROB_LENGTH)
) (
   input  logic              clk,
   input  logic              n_rst,
   alu_exec_unit_if.slave    issue,
   output logic              eb_retain,
   output logic [RW-1:0]     ra_rd_addr,
   input  logic [DATA_W-1:0] ra_rd_data,
   output logic [RW-1:0]     rt_rd_addr,
   input  logic [DATA_W-1:0] rt_rd_data,
   output logic              wb_req,
   input  logic              wb_grant,
   output logic              wb_d_we,
   output logic [RW-1:0]     wb_d_addr,
   output logic [DATA_W-1:0] wb_d_data,
   output logic              wb_s_we,
   output logic [SW-1:0]     wb_s_addr,
   output logic [1:0]        wb_s_data,
   output logic              calc_set,
   output logic              rob_done,
   output logic [QW-1:0]     rob_done_addr,
   input  logic              restore,
   input  logic [QW-1:0]     cp_tail,
   input  logic [QW-1:0]     rob_head
);
   localparam logic [3:0] OP_NAND = 4'd0, OP_AND = 4'd1, OP_OR  = 4'd2, OP_XOR = 4'd3,
                          OP_ADD  = 4'd4, OP_SUB = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7;

   typedef struct packed {
      logic [QW-1:0] rob;
      logic [3:0]    op;
      logic [5:0]    immdt;
      logic [RW-1:0] ra;
      logic [RW-1:0] rt;
      logic          use_rt;
      logic          write_dst;
      logic [RW-1:0] rw;
      logic [SW-1:0] rs;
   } s1_t;

   typedef struct packed {
      logic [QW-1:0]     rob;
      logic [3:0]        op;
      logic              write_dst;
      logic [RW-1:0]     rw;
      logic [SW-1:0]     rs;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } s2_t;

   logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   logic s1_live, s2_live, issue_live, stall;
   logic [DATA_W-1:0] op_a, op_b, op_b_reg, result;

   // Surviving window is [head, tail) modulo ROB size; head == tail means nothing survives.
   function automatic logic survives(input logic [QW-1:0] a, input logic [QW-1:0] head,
                                     input logic [QW-1:0] tail);
      if (tail > head) return (a >= head) && (a < tail);
      if (tail < head) return (a >= head) || (a < tail);
      return 1'b0;
   endfunction

   always_comb begin
      result = '0;
      case (s2_q.op)
         OP_NAND: result = ~(s2_q.a & s2_q.b);
         OP_AND:  result = s2_q.a & s2_q.b;
         OP_OR:   result = s2_q.a | s2_q.b;
         OP_XOR:  result = s2_q.a ^ s2_q.b;
         OP_ADD:  result = s2_q.a + s2_q.b;
         OP_SUB:  result = s2_q.a - s2_q.b;
         OP_SHL:  result = s2_q.a << s2_q.b[2:0];
         OP_SHR:  result = s2_q.a >> s2_q.b[2:0];
         default: result = '0;
      endcase
   end

   always_comb begin
      s1_live    = s1_valid_q & ~(restore & ~survives(s1_q.rob, rob_head, cp_tail));
      s2_live    = s2_valid_q & ~(restore & ~survives(s2_q.rob, rob_head, cp_tail));
      issue_live = issue.valid & ~(restore & ~survives(issue.rob_addr, rob_head, cp_tail));
      stall      = s2_valid_q & ~wb_grant;
      eb_retain  = stall & s1_valid_q;

      wb_req        = s2_live;
      rob_done      = s2_live & wb_grant;
      wb_s_we       = rob_done;
      wb_d_we       = rob_done & s2_q.write_dst;
      calc_set      = wb_d_we;
      wb_d_addr     = s2_q.rw;
      wb_s_addr     = s2_q.rs;
      rob_done_addr = s2_q.rob;
      wb_d_data     = s2_valid_q ? result : '0;
      wb_s_data     = s2_valid_q ? {result[DATA_W-1], result == '0} : 2'b00;

      ra_rd_addr = s1_q.ra;
      rt_rd_addr = s1_q.rt;
      op_a       = ra_rd_data;
      op_b_reg   = rt_rd_data;
`ifdef ALU_BYPASS_EN
      if (s2_live && s2_q.write_dst && (s2_q.rw == s1_q.ra)) op_a     = wb_d_data;
      if (s2_live && s2_q.write_dst && (s2_q.rw == s1_q.rt)) op_b_reg = wb_d_data;
`endif
      op_b = s1_q.use_rt ? op_b_reg : DATA_W'($signed(s1_q.immdt));

      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;

      // A killed op frees its stage even while the stage would otherwise hold.
      if (stall) begin
         s2_valid_d = s2_live;
      end else begin
         s2_valid_d = s1_live;
         if (s1_live) begin
            s2_d = '{rob: s1_q.rob, op: s1_q.op, write_dst: s1_q.write_dst,
                     rw: s1_q.rw, rs: s1_q.rs, a: op_a, b: op_b};
         end
      end

      if (eb_retain) begin
         s1_valid_d = s1_live;
      end else begin
         s1_valid_d = issue_live;
         if (issue_live) begin
            s1_d = '{rob: issue.rob_addr, op: issue.alu_op, immdt: issue.immdt,
                     ra: issue.ra_addr, rt: issue.rt_addr, use_rt: issue.use_rt,
                     write_dst: issue.write_dst, rw: issue.rw_addr, rs: issue.rs_addr};
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end
endmodule
